elastic_pipe: RTL

- N-stage pipeline delay register with a valid/ready handshake at both ends.
- It is the backpressure-aware counterpart of the plain enable-driven delay chain. The producer side pushes with valid; the consumer side pulls with ready.
- Stages are bubble-collapsing: a stage advances whenever the stage downstream of it is empty or is draining.
- Used between brisc pipeline units whose consumer can stall, e.g. multi-cycle memory response paths. Flush support covers branch/exception squash.

---
 rtl/elastic_pipe_if.sv | 30 +++
 rtl/elastic_pipe.sv | 113 +++++++++++
 2 files changed

// File: rtl/elastic_pipe_if.sv
// Handshake bundle for elastic_pipe: producer-side push and consumer-side pull.
// The pipe connects through the slave modport; the driving agent uses master.
interface elastic_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      input  out_ready
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      output out_ready
   );
endinterface

// File: rtl/elastic_pipe.sv
// N-stage valid/ready delay pipe with bubble collapse, flush and occupancy count.
// Define ELASTIC_PIPE_STALL_CNT_EN to add a saturating output-stall counter (stall_cnt).
module elastic_pipe #(
   parameter int               N           = 3,
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   elastic_pipe_if.slave          io,
   output logic [$clog2(N+1)-1:0] occupancy
`ifdef ELASTIC_PIPE_STALL_CNT_EN
   ,
   output logic [31:0]            stall_cnt
`endif
);
   localparam int OW = $clog2(N+1);

   logic [N-1:0]     vld_q;
   logic [N-1:0]     vld_d;
   logic [N-1:0]     mv;
   logic [N-1:0]     src_vld;
   logic [WIDTH-1:0] dat_q   [N];
   logic [WIDTH-1:0] dat_d   [N];
   logic [WIDTH-1:0] src_dat [N];
   logic [OW-1:0]    occ_sum;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_src
         if (gi == 0) begin : g_head
            assign src_vld[gi] = io.in_valid;
            assign src_dat[gi] = io.in_data;
         end else begin : g_body
            assign src_vld[gi] = vld_q[gi-1];
            assign src_dat[gi] = dat_q[gi-1];
         end
      end
   endgenerate

   // A stage may load when it is empty or the stage ahead is empty or draining.
   always_comb begin
      mv      = '0;
      mv[N-1] = io.out_ready | ~vld_q[N-1];
      for (int i = N - 2; i >= 0; i--) begin
         mv[i] = mv[i+1] | ~vld_q[i+1] | ~vld_q[i];
      end
   end

   always_comb begin
      vld_d = vld_q;
      for (int i = 0; i < N; i++) begin
         dat_d[i] = dat_q[i];
         if (flush) begin
            vld_d[i] = 1'b0;
            dat_d[i] = RESET_VALUE;
         end else if (mv[i]) begin
            vld_d[i] = src_vld[i];
            if (src_vld[i]) begin
               dat_d[i] = src_dat[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_q <= '0;
         for (int i = 0; i < N; i++) begin
            dat_q[i] <= RESET_VALUE;
         end
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   always_comb begin
      occ_sum = '0;
      for (int i = 0; i < N; i++) begin
         occ_sum = occ_sum + OW'(vld_q[i]);
      end
   end

   assign occupancy    = occ_sum;
   assign io.in_ready  = ~vld_q[0] | mv[0];
   assign io.out_valid = vld_q[N-1];
   assign io.out_data  = dat_q[N-1];

`ifdef ELASTIC_PIPE_STALL_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;

   // Survives flush on purpose: it measures consumer backpressure, not pipe contents.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (vld_q[N-1] && !io.out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif
endmodule
